dht11_reader: RTL

DHT11_READER -- requirements
Module: dht11_reader

---
 rtl/dht11_reader.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire sensor reader.
// Sends the host start pulse, follows the sensor handshake, and decodes the
// 40-bit frame by measuring each bit's high time. The result is published
// only when the checksum matches; otherwise a sticky error code is reported.
module dht11_reader #(
  parameter int unsigned TICKS_PER_US    = 100,
  parameter int unsigned START_LOW_US    = 18000,
  parameter int unsigned RESP_TIMEOUT_US = 100,
  parameter int unsigned BIT_THRESH_US   = 40
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       start,
  inout  wire        dht_data,
  output logic       busy,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic [1:0] err,
  output logic       err_pulse
);

  localparam logic [23:0] START_CYC_M1   = 24'(START_LOW_US * TICKS_PER_US - 1);
  localparam logic [23:0] TIMEOUT_CYC_M1 = 24'(RESP_TIMEOUT_US * TICKS_PER_US - 1);
  localparam logic [23:0] THRESH_CYC     = 24'(BIT_THRESH_US * TICKS_PER_US);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_RELEASE   = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7,
    S_DONE      = 4'd8,
    S_ERR       = 4'd9
  } state_t;

  // Sum of the four data bytes modulo 256 must equal the fifth byte.
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return (sum == frame[7:0]);
  endfunction

  state_t      state_r, state_nx_s;
  logic [23:0] cnt_r;
  logic [39:0] shift_r;
  logic [5:0]  bit_idx_r;
  logic        sync1_r, sync2_r;
  logic [1:0]  echo_r;
  logic        drive_low_r;
  logic        busy_r, data_valid_r, err_pulse_r;
  logic [1:0]  err_r;
  logic [7:0]  hum_int_r, hum_dec_r, temp_int_r, temp_dec_r;
  logic        line_s;
  logic [1:0]  err_code_s;
  logic        shift_en_s;
  logic        bit_val_s;
  logic        timeout_s;

  // Open-drain: the block only ever pulls the wire low or lets it float.
  assign dht_data = drive_low_r ? 1'b0 : 1'bz;

  // Our own start pulse takes two synchronizer stages to drain after release;
  // treat the line as high during that window so it is not mistaken for the
  // sensor's response.
  assign line_s    = sync2_r | drive_low_r | echo_r[0] | echo_r[1];
  assign timeout_s = (cnt_r >= TIMEOUT_CYC_M1);

  assign busy       = busy_r;
  assign data_valid = data_valid_r;
  assign err        = err_r;
  assign err_pulse  = err_pulse_r;
  assign hum_int    = hum_int_r;
  assign hum_dec    = hum_dec_r;
  assign temp_int   = temp_int_r;
  assign temp_dec   = temp_dec_r;

  // Two-flop synchronizer for the bus plus history of our own drive.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      echo_r  <= 2'b00;
    end else begin
      sync1_r <= dht_data;
      sync2_r <= sync1_r;
      echo_r  <= {echo_r[0], drive_low_r};
    end
  end

  // State register and per-state duration counter (cleared on every entry).
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 24'd0;
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s != state_r) begin
        cnt_r <= 24'd0;
      end else begin
        cnt_r <= cnt_r + 24'd1;
      end
    end
  end

  // Next-state logic for the read sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE:      if (start) state_nx_s = S_START_LOW; else state_nx_s = S_IDLE;
      S_START_LOW: if (cnt_r >= START_CYC_M1) state_nx_s = S_RELEASE; else state_nx_s = S_START_LOW;
      S_RELEASE: begin
        if (!line_s)        state_nx_s = S_RESP_LOW;
        else if (timeout_s) state_nx_s = S_ERR;
        else                state_nx_s = S_RELEASE;
      end
      S_RESP_LOW: begin
        if (line_s)         state_nx_s = S_RESP_HIGH;
        else if (timeout_s) state_nx_s = S_ERR;
        else                state_nx_s = S_RESP_LOW;
      end
      S_RESP_HIGH: begin
        if (!line_s)        state_nx_s = S_BIT_LOW;
        else if (timeout_s) state_nx_s = S_ERR;
        else                state_nx_s = S_RESP_HIGH;
      end
      S_BIT_LOW: begin
        if (line_s)         state_nx_s = S_BIT_HIGH;
        else if (timeout_s) state_nx_s = S_ERR;
        else                state_nx_s = S_BIT_LOW;
      end
      S_BIT_HIGH: begin
        if (!line_s) begin
          if (bit_idx_r == 6'd39) state_nx_s = S_CHECK;
          else                    state_nx_s = S_BIT_LOW;
        end else if (timeout_s) begin
          state_nx_s = S_ERR;
        end else begin
          state_nx_s = S_BIT_HIGH;
        end
      end
      S_CHECK:     if (checksum_ok(shift_r)) state_nx_s = S_DONE; else state_nx_s = S_ERR;
      S_DONE:      state_nx_s = S_IDLE;
      S_ERR:       state_nx_s = S_IDLE;
      default:     state_nx_s = S_IDLE;
    endcase
  end

  // Per-state decode: error class of the phase and bit sampling strobe.
  always_comb begin
    err_code_s = 2'b00;
    shift_en_s = 1'b0;
    bit_val_s  = 1'b0;
    case (state_r)
      S_RELEASE, S_RESP_LOW, S_RESP_HIGH: err_code_s = 2'b01;
      S_BIT_LOW:                          err_code_s = 2'b10;
      S_BIT_HIGH: begin
        err_code_s = 2'b10;
        if (!line_s) shift_en_s = 1'b1; else shift_en_s = 1'b0;
        if (cnt_r > THRESH_CYC) bit_val_s = 1'b1; else bit_val_s = 1'b0;
      end
      S_CHECK:                            err_code_s = 2'b11;
      default:                            err_code_s = 2'b00;
    endcase
  end

  // Registered control outputs, aligned with the state they belong to.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      drive_low_r  <= 1'b0;
      busy_r       <= 1'b0;
      data_valid_r <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_r        <= 2'b00;
    end else begin
      drive_low_r  <= (state_nx_s == S_START_LOW);
      busy_r       <= (state_nx_s != S_IDLE);
      data_valid_r <= (state_nx_s == S_DONE);
      err_pulse_r  <= (state_nx_s == S_ERR);
      if (state_r == S_IDLE && start) begin
        err_r <= 2'b00;
      end else if (state_nx_s == S_ERR) begin
        err_r <= err_code_s;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // Frame shift register, bit index and published data bytes.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      shift_r    <= 40'd0;
      bit_idx_r  <= 6'd0;
      hum_int_r  <= 8'd0;
      hum_dec_r  <= 8'd0;
      temp_int_r <= 8'd0;
      temp_dec_r <= 8'd0;
    end else begin
      if (state_r == S_IDLE && start) begin
        shift_r <= 40'd0;
      end else if (shift_en_s) begin
        shift_r <= {shift_r[38:0], bit_val_s};
      end
      if (state_r == S_RESP_HIGH) begin
        bit_idx_r <= 6'd0;
      end else if (shift_en_s) begin
        bit_idx_r <= bit_idx_r + 6'd1;
      end
      if (state_nx_s == S_DONE) begin
        hum_int_r  <= shift_r[39:32];
        hum_dec_r  <= shift_r[31:24];
        temp_int_r <= shift_r[23:16];
        temp_dec_r <= shift_r[15:8];
      end
    end
  end

endmodule
